// File: rtl/cve2_pkg.sv
// Shared types and constants for the register-file writeback scheduler slice.
package cve2_pkg;

  localparam int unsigned RegAddrW = 5;
  // Width of the data field in the buffered result; DataWidth must not exceed this.
  localparam int unsigned XDataW   = 32;

  // Number of architectural registers, including x0.
  function automatic int unsigned num_regs(input bit rv32e);
    return rv32e ? 32'd16 : 32'd32;
  endfunction

  // One buffered coprocessor result.
  typedef struct packed {
    logic [RegAddrW-1:0] rd;
    logic [XDataW-1:0]   data;
    logic                we;
  } x_result_buf_t;

endpackage

// File: rtl/cve2_rf_wb_scheduler_if.sv
// Coprocessor result channel: the coprocessor is the master, the scheduler the slave.
interface cve2_rf_wb_scheduler_if #(
  parameter int unsigned DataWidth = 32
);
  logic                 x_result_valid;
  logic                 x_result_ready;
  logic [4:0]           x_result_rd;
  logic [DataWidth-1:0] x_result_data;
  logic                 x_result_we;

  modport master (
    output x_result_valid,
    output x_result_rd,
    output x_result_data,
    output x_result_we,
    input  x_result_ready
  );

  modport slave (
    input  x_result_valid,
    input  x_result_rd,
    input  x_result_data,
    input  x_result_we,
    output x_result_ready
  );
endinterface

// File: rtl/cve2_rf_scoreboard.sv
// Per-register pending bits for outstanding coprocessor writes. x0 has no bit, and addresses
// beyond the register count never set or report a pending bit.
module cve2_rf_scoreboard
  import cve2_pkg::*;
#(
  parameter bit RV32E = 1'b0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                set_i,
  input  logic [RegAddrW-1:0] set_addr_i,
  output logic                set_hit_o,
  input  logic                clr_i,
  input  logic [RegAddrW-1:0] clr_addr_i,
  output logic                clr_hit_o,
  input  logic [RegAddrW-1:0] look_a_addr_i,
  output logic                look_a_hit_o,
  input  logic [RegAddrW-1:0] look_b_addr_i,
  output logic                look_b_hit_o,
  input  logic [RegAddrW-1:0] look_c_addr_i,
  output logic                look_c_hit_o
);

  localparam int unsigned NumRegs = num_regs(RV32E);

  logic [NumRegs-1:1] pend_q, pend_d;
  logic [31:0]        w_pend_ext;

  // Zero-extended view so every 5-bit address indexes safely; x0 and missing regs read 0.
  assign w_pend_ext   = 32'({pend_q, 1'b0});
  assign set_hit_o    = w_pend_ext[set_addr_i];
  assign clr_hit_o    = w_pend_ext[clr_addr_i];
  assign look_a_hit_o = w_pend_ext[look_a_addr_i];
  assign look_b_hit_o = w_pend_ext[look_b_addr_i];
  assign look_c_hit_o = w_pend_ext[look_c_addr_i];

  // Next pending vector: a same-cycle set of the same register wins over a clear.
  always_comb begin
    pend_d = pend_q;
    for (int unsigned i = 1; i < NumRegs; i++) begin
      if (clr_i && (clr_addr_i == 5'(i))) pend_d[i] = 1'b0;
      if (set_i && (set_addr_i == 5'(i))) pend_d[i] = 1'b1;
    end
  end

  // Pending vector register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pend_q <= '0;
    else         pend_q <= pend_d;
  end

endmodule

// File: rtl/cve2_rf_wb_scheduler.sv
// Register-file write port sequencer: core writeback has priority, one coprocessor result is
// held in a skid buffer, and a starvation counter asks the core to back off.
module cve2_rf_wb_scheduler
  import cve2_pkg::*;
#(
  parameter bit          RV32E     = 1'b0,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned MaxWait   = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 wb_we_i,
  input  logic [4:0]           wb_waddr_i,
  input  logic [DataWidth-1:0] wb_wdata_i,
  output logic                 wb_hold_o,
  input  logic                 x_issue_valid_i,
  input  logic [4:0]           x_issue_rd_i,
  output logic                 x_issue_stall_o,
  cve2_rf_wb_scheduler_if.slave x_result,
  input  logic [4:0]           rs_a_i,
  input  logic [4:0]           rs_b_i,
  output logic                 hazard_o,
  output logic                 spurious_o,
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o
);

  typedef enum logic {StEmpty, StFull} buf_state_e;

  buf_state_e    state_q, state_d;
  x_result_buf_t buf_q;
  logic [3:0]    wait_q, wait_d;

  logic w_full, w_handshake, w_commit;
  logic w_issue_hit, w_clr_hit, w_hit_a, w_hit_b, w_hit_wb;

  assign w_full      = (state_q == StFull);
  assign w_handshake = x_result.x_result_valid & ~w_full;
  // The buffer drains only in cycles the core leaves the port free.
  assign w_commit    = w_full & ~wb_we_i;

  assign x_result.x_result_ready = ~w_full;
  assign x_issue_stall_o         = x_issue_valid_i & w_issue_hit;
  assign hazard_o                = w_hit_a | w_hit_b | (wb_we_i & w_hit_wb);
  assign spurious_o              = w_commit & ~w_clr_hit;
  assign wb_hold_o               = (wait_q >= 4'(MaxWait));

  cve2_rf_scoreboard #(
    .RV32E (RV32E)
  ) u_scoreboard (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .set_i         (x_issue_valid_i & ~w_issue_hit),
    .set_addr_i    (x_issue_rd_i),
    .set_hit_o     (w_issue_hit),
    .clr_i         (w_commit),
    .clr_addr_i    (buf_q.rd),
    .clr_hit_o     (w_clr_hit),
    .look_a_addr_i (rs_a_i),
    .look_a_hit_o  (w_hit_a),
    .look_b_addr_i (rs_b_i),
    .look_b_hit_o  (w_hit_b),
    .look_c_addr_i (wb_waddr_i),
    .look_c_hit_o  (w_hit_wb)
  );

  // Buffer occupancy next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (w_handshake) state_d = StFull;
      StFull:  if (w_commit)    state_d = StEmpty;
    endcase
  end

  // Buffer occupancy register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= StEmpty;
    else         state_q <= state_d;
  end

  // Skid buffer payload, captured on the result handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_q <= '0;
    end else if (w_handshake) begin
      buf_q <= '{rd:   x_result.x_result_rd,
                 data: XDataW'(x_result.x_result_data),
                 we:   x_result.x_result_we};
    end
  end

  // Starvation counter: counts blocked cycles, saturates at MaxWait, clears on commit.
  always_comb begin
    wait_d = wait_q;
    if (w_commit) begin
      wait_d = '0;
    end else if (w_full && wb_we_i && (wait_q < 4'(MaxWait))) begin
      wait_d = wait_q + 4'd1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) wait_q <= '0;
    else         wait_q <= wait_d;
  end

  // Write port mux: core writeback first, otherwise the buffered result.
  always_comb begin
    rf_we_o    = 1'b0;
    rf_waddr_o = buf_q.rd;
    rf_wdata_o = DataWidth'(buf_q.data);
    if (wb_we_i) begin
      rf_we_o    = (wb_waddr_i != 5'd0);
      rf_waddr_o = wb_waddr_i;
      rf_wdata_o = wb_wdata_i;
    end else if (w_full) begin
      rf_we_o = buf_q.we & (buf_q.rd != 5'd0);
    end
  end

endmodule

// File: tb/tb_cve2_rf_wb_scheduler.sv
// Scoreboard bench: the driver computes each cycle's expected outputs from a reference model
// and queues them; a monitor pops one entry per cycle and compares it with the DUT.
module tb_cve2_rf_wb_scheduler;

  localparam int MaxWait = 4;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        x_issue_valid;
  logic [4:0]  x_issue_rd;
  logic [4:0]  rs_a, rs_b;

  logic        wb_hold, x_issue_stall, hazard, spurious, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        wb_hold_e, x_issue_stall_e, hazard_e, spurious_e, rf_we_e;
  logic [4:0]  rf_waddr_e;
  logic [31:0] rf_wdata_e;

  always #5 clk = ~clk;

  cve2_rf_wb_scheduler_if #(.DataWidth(32)) xif ();
  cve2_rf_wb_scheduler_if #(.DataWidth(32)) xif_e ();

  assign xif_e.x_result_valid = xif.x_result_valid;
  assign xif_e.x_result_rd    = xif.x_result_rd;
  assign xif_e.x_result_data  = xif.x_result_data;
  assign xif_e.x_result_we    = xif.x_result_we;

  cve2_rf_wb_scheduler #(.RV32E(1'b0), .DataWidth(32), .MaxWait(MaxWait)) dut (
    .clk_i (clk), .rst_ni (rst_ni),
    .wb_we_i (wb_we), .wb_waddr_i (wb_waddr), .wb_wdata_i (wb_wdata), .wb_hold_o (wb_hold),
    .x_issue_valid_i (x_issue_valid), .x_issue_rd_i (x_issue_rd),
    .x_issue_stall_o (x_issue_stall), .x_result (xif.slave),
    .rs_a_i (rs_a), .rs_b_i (rs_b), .hazard_o (hazard), .spurious_o (spurious),
    .rf_we_o (rf_we), .rf_waddr_o (rf_waddr), .rf_wdata_o (rf_wdata)
  );

  cve2_rf_wb_scheduler #(.RV32E(1'b1), .DataWidth(32), .MaxWait(MaxWait)) dut_e (
    .clk_i (clk), .rst_ni (rst_ni),
    .wb_we_i (wb_we), .wb_waddr_i (wb_waddr), .wb_wdata_i (wb_wdata), .wb_hold_o (wb_hold_e),
    .x_issue_valid_i (x_issue_valid), .x_issue_rd_i (x_issue_rd),
    .x_issue_stall_o (x_issue_stall_e), .x_result (xif_e.slave),
    .rs_a_i (rs_a), .rs_b_i (rs_b), .hazard_o (hazard_e), .spurious_o (spurious_e),
    .rf_we_o (rf_we_e), .rf_waddr_o (rf_waddr_e), .rf_wdata_o (rf_wdata_e)
  );

  typedef struct {
    logic        ready, hold, hazard, stall, spurious, rf_we;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        we;
  } res_t;

  exp_t exp_q[$];
  res_t m_buf[$];
  bit   m_pend[32];
  int   m_wait;
  int   n_cmp = 0;
  int   n_fail = 0;

  function automatic void check1(input string name, input logic act, input logic want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, want, $time);
    end
  endfunction

  function automatic void check32(input string name, input logic [31:0] act,
                                  input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, want, $time);
    end
  endfunction

  function automatic void model_reset();
    m_buf.delete();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_wait = 0;
  endfunction

  // One clock cycle: apply inputs, predict outputs, advance the model.
  task automatic drive_cycle(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                             input logic iv, input logic [4:0] ird,
                             input logic rv, input logic [4:0] rrd, input logic [31:0] rdat,
                             input logic rwe, input logic [4:0] ra, input logic [4:0] rb);
    exp_t e;
    res_t r;
    bit   full, commit;
    @(posedge clk);
    #1;
    wb_we = we; wb_waddr = wa; wb_wdata = wd;
    x_issue_valid = iv; x_issue_rd = ird;
    xif.x_result_valid = rv; xif.x_result_rd = rrd;
    xif.x_result_data = rdat; xif.x_result_we = rwe;
    rs_a = ra; rs_b = rb;

    full       = (m_buf.size() != 0);
    commit     = full && !we;
    e.ready    = !full;
    e.hold     = (m_wait >= MaxWait);
    e.hazard   = m_pend[ra] || m_pend[rb] || (we && m_pend[wa]);
    e.stall    = iv && m_pend[ird];
    e.spurious = 1'b0;
    e.rf_we    = 1'b0;
    e.addr     = '0;
    e.data     = '0;
    if (we) begin
      e.rf_we = (wa != 0);
      e.addr  = wa;
      e.data  = wd;
    end else if (commit) begin
      r          = m_buf[0];
      e.rf_we    = r.we && (r.rd != 0);
      e.addr     = r.rd;
      e.data     = r.data;
      e.spurious = !m_pend[r.rd];
    end
    exp_q.push_back(e);

    if (commit) begin
      m_pend[m_buf[0].rd] = 1'b0;
      void'(m_buf.pop_front());
      m_wait = 0;
    end else if (full && we) begin
      m_wait = (m_wait + 1 > MaxWait) ? MaxWait : m_wait + 1;
    end
    if (iv && !e.stall && ird != 0) m_pend[ird] = 1'b1;
    if (rv && !full) begin
      r = '{rrd, rdat, rwe};
      m_buf.push_back(r);
    end
  endtask

  task automatic idle(input logic [4:0] ra);
    drive_cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, ra, 5'd0);
  endtask

  function automatic logic [4:0] rnd_reg();
    if ($urandom_range(0, 9) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  task automatic random_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      drive_cycle($urandom_range(0, 99) < 45, rnd_reg(), $urandom(),
                  $urandom_range(0, 99) < 30, rnd_reg(),
                  $urandom_range(0, 99) < 50, rnd_reg(), $urandom(),
                  $urandom_range(0, 99) < 85, rnd_reg(), rnd_reg());
    end
  endtask

  // Monitor: compare one queued expectation per cycle, mid-cycle.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check1("ready", xif.x_result_ready, e.ready);
        check1("wb_hold", wb_hold, e.hold);
        check1("hazard", hazard, e.hazard);
        check1("issue_stall", x_issue_stall, e.stall);
        check1("spurious", spurious, e.spurious);
        check1("rf_we", rf_we, e.rf_we);
        if (e.rf_we) begin
          check32("rf_waddr", 32'(rf_waddr), 32'(e.addr));
          check32("rf_wdata", rf_wdata, e.data);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin : main
    wb_we = 0; wb_waddr = 0; wb_wdata = 0;
    x_issue_valid = 1; x_issue_rd = 5'd9; rs_a = 5'd9; rs_b = 0;
    xif.x_result_valid = 0; xif.x_result_rd = 0; xif.x_result_data = 0; xif.x_result_we = 0;
    model_reset();

    // Reset values.
    #2;
    check1("rst_ready", xif.x_result_ready, 1'b1);
    check1("rst_rf_we", rf_we, 1'b0);
    check1("rst_hold", wb_hold, 1'b0);
    check1("rst_hazard", hazard, 1'b0);
    check1("rst_stall", x_issue_stall, 1'b0);
    check1("rst_spurious", spurious, 1'b0);
    x_issue_valid = 0; rs_a = 0;
    #10 rst_ni = 1'b1;

    // Issue x5, result 0xDEADBEEF, commit with wb idle.
    drive_cycle(0, 0, 0, 1, 5'd5, 0, 0, 0, 0, 5'd5, 0);
    idle(5'd5);
    idle(5'd5);
    drive_cycle(0, 0, 0, 0, 0, 1, 5'd5, 32'hDEADBEEF, 1, 5'd5, 0);
    idle(5'd5);
    idle(5'd5);

    // Result for x7 starved by a busy core for 6 cycles.
    drive_cycle(0, 0, 0, 1, 5'd7, 0, 0, 0, 0, 0, 0);
    drive_cycle(1, 5'd1, 32'h1111_0000, 0, 0, 1, 5'd7, 32'h0707_0707, 1, 5'd7, 0);
    for (int k = 0; k < 6; k++) drive_cycle(1, 5'd2, 32'h2222_0000 + k, 0, 0, 0, 0, 0, 0, 5'd7, 0);
    idle(5'd7);
    idle(5'd7);

    // Back-to-back issue to x3 stalls until the x3 commit has passed.
    drive_cycle(0, 0, 0, 1, 5'd3, 0, 0, 0, 0, 0, 0);
    drive_cycle(0, 0, 0, 1, 5'd3, 0, 0, 0, 0, 0, 0);
    drive_cycle(0, 0, 0, 1, 5'd3, 1, 5'd3, 32'h3333_3333, 1, 0, 0);
    drive_cycle(0, 0, 0, 1, 5'd3, 0, 0, 0, 0, 0, 0);
    drive_cycle(0, 0, 0, 1, 5'd3, 0, 0, 0, 0, 0, 0);
    drive_cycle(0, 0, 0, 0, 0, 1, 5'd3, 32'h3030_3030, 1, 5'd3, 0);
    idle(5'd3);

    // Result to x0 drains without a write; result with we=0 clears its pending bit.
    drive_cycle(0, 0, 0, 0, 0, 1, 5'd0, 32'h0BAD_0BAD, 1, 0, 0);
    idle(0);
    drive_cycle(0, 0, 0, 1, 5'd6, 0, 0, 0, 0, 0, 0);
    drive_cycle(0, 0, 0, 0, 0, 1, 5'd6, 32'h6666_6666, 0, 5'd6, 0);
    idle(5'd6);
    idle(5'd6);

    // Core write to x0 passes through with no write enable.
    drive_cycle(1, 5'd0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 0);

    // RV32E: x20 does not exist, so it never becomes pending.
    drive_cycle(0, 0, 0, 1, 5'd20, 0, 0, 0, 0, 0, 0);
    drive_cycle(0, 0, 0, 1, 5'd20, 0, 0, 0, 0, 5'd20, 0);
    check1("rv32e_stall", x_issue_stall_e, 1'b0);
    check1("rv32e_hazard", hazard_e, 1'b0);
    drive_cycle(0, 0, 0, 0, 0, 1, 5'd20, 32'h2020_2020, 1, 0, 0);
    idle(0);

    random_cycles(400);

    // Reset with a buffered result and x9 pending.
    drive_cycle(0, 0, 0, 1, 5'd9, 0, 0, 0, 0, 0, 0);
    drive_cycle(1, 5'd1, 32'h1, 0, 0, 1, 5'd9, 32'h9999_9999, 1, 5'd9, 0);
    drive_cycle(1, 5'd1, 32'h2, 0, 0, 0, 0, 0, 0, 5'd9, 0);
    @(negedge clk);
    #2;
    rst_ni = 1'b0;
    wb_we = 0; x_issue_valid = 1; x_issue_rd = 5'd9; rs_a = 5'd9;
    #1;
    check1("mid_rst_ready", xif.x_result_ready, 1'b1);
    check1("mid_rst_rf_we", rf_we, 1'b0);
    check1("mid_rst_hold", wb_hold, 1'b0);
    check1("mid_rst_hazard", hazard, 1'b0);
    check1("mid_rst_stall", x_issue_stall, 1'b0);
    check1("mid_rst_spurious", spurious, 1'b0);
    x_issue_valid = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    idle(5'd9);
    idle(0);
    random_cycles(60);

    repeat (3) @(posedge clk);
    check32("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
